// File: rtl/act_sched_pkg.sv
// act_sched_pkg: shared definitions for the activation interpolation scheduler.
//   ACT_DATA_W / ACT_FRAC_W : default Q4.4 data and fraction widths
//   state_t                 : scheduler FSM states
//   act_sext                : sign-extend a data word by FRAC_W bits
//   act_clamp               : saturate a wide signed sum to the data range
package act_sched_pkg;

    localparam int ACT_DATA_W = 8;
    localparam int ACT_FRAC_W = 4;
    localparam int ACT_EXT_W  = ACT_DATA_W + ACT_FRAC_W;
    localparam int ACT_WIDE_W = ACT_DATA_W + ACT_FRAC_W + 2;

    localparam logic signed [ACT_WIDE_W-1:0] ACT_MAX = ACT_WIDE_W'(2 ** (ACT_DATA_W - 1) - 1);
    localparam logic signed [ACT_WIDE_W-1:0] ACT_MIN = ACT_WIDE_W'(-(2 ** (ACT_DATA_W - 1)));

    typedef enum logic [2:0] {
        IDLE,
        RD_BASE,
        RD_NEXT,
        CALC,
        RESP
    } state_t;

    function automatic logic signed [ACT_EXT_W-1:0] act_sext(input logic [ACT_DATA_W-1:0] v);
        return {{ACT_FRAC_W{v[ACT_DATA_W-1]}}, v};
    endfunction

    function automatic logic [ACT_DATA_W-1:0] act_clamp(input logic signed [ACT_WIDE_W-1:0] v);
        if (v > ACT_MAX) begin
            return ACT_DATA_W'(ACT_MAX);
        end
        if (v < ACT_MIN) begin
            return ACT_DATA_W'(ACT_MIN);
        end
        return ACT_DATA_W'(v);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N_REQ requesters.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector
//   adv      : advance strobe; when set with any request, pointer moves past the grant
//   grant    : one-hot grant to first requester at or after the pointer
//   ptr      : current round-robin pointer
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    always_comb begin : pick
        int unsigned k;
        k       = 0;
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(ptr) + i) % N_REQ;
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = PTR_W'((k + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/act_interp_scheduler.sv
// act_interp_scheduler: time-shares one piecewise-linear activation datapath
// (signed Q4.4) between N_REQ requesters. Grants round-robin, reads two adjacent
// entries from an external synchronous LUT, interpolates, returns the result.
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-requester request strobe
//   req_x      : per-requester x, lane i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot accept pulse in the grant cycle
//   lut_rd     : LUT read enable; lut_addr : LUT index; lut_data : entry, 1 cycle later
//   resp_valid : one-hot result valid for the granted lane, held until resp_ready
//   resp_ready : per-lane result accept (only the granted lane matters)
//   resp_y     : interpolated result
// Build option ACT_SAT_EN: widened difference and saturating sum instead of
// 8-bit wrapping arithmetic.
module act_interp_scheduler
    import act_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = ACT_DATA_W,
    parameter int FRAC_W = ACT_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_x,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    lut_rd,
    output logic [FRAC_W-1:0]       lut_addr,
    input  logic [DATA_W-1:0]       lut_data,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]       resp_y
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic               adv;
    logic [DATA_W-1:0]  x_q, base_q, y_q, x_sel, y_calc;
    logic [FRAC_W-1:0]  idx, idx_nxt, rem;
    logic [PTR_W-1:0]   resp_lane;
    logic [N_REQ-1:0]   resp_oh;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .adv   (adv),
        .grant (grant),
        .ptr   (rr_ptr)
    );

    always_comb begin
        x_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                x_sel = req_x[i*DATA_W +: DATA_W];
            end
        end
    end

    // Offset-binary index: idx 0 corresponds to x = -8.0.
    assign idx     = {~x_q[DATA_W-1], x_q[DATA_W-2:FRAC_W]};
    assign idx_nxt = (idx == '1) ? idx : idx + 1'b1;
    assign rem     = x_q[FRAC_W-1:0];

    // The pointer sits one past the granted lane for the whole job, so the
    // response lane is recovered from it rather than stored separately.
    always_comb begin
        resp_lane          = (rr_ptr == '0) ? PTR_W'(N_REQ - 1) : rr_ptr - 1'b1;
        resp_oh            = '0;
        resp_oh[resp_lane] = 1'b1;
    end

    // In CALC lut_data holds the next entry; it feeds y directly.
`ifdef ACT_SAT_EN
    localparam int DIFF_W = DATA_W + 1;
    localparam int WIDE_W = DATA_W + FRAC_W + 2;
    logic signed [DIFF_W-1:0] diff_w;
    logic signed [WIDE_W-1:0] prod_w;
    always_comb begin
        diff_w = DIFF_W'($signed(lut_data)) - DIFF_W'($signed(base_q));
        prod_w = WIDE_W'(diff_w) * WIDE_W'($signed({1'b0, rem}));
        y_calc = act_clamp(WIDE_W'($signed(base_q)) + (prod_w >>> FRAC_W));
    end
`else
    localparam int EXT_W = DATA_W + FRAC_W;
    logic signed [EXT_W-1:0] prod_e;
    always_comb begin
        prod_e = act_sext(lut_data - base_q) * EXT_W'($signed({1'b0, rem}));
        y_calc = DATA_W'(act_sext(base_q) + (prod_e >>> FRAC_W));
    end
`endif

    always_comb begin
        state_nxt  = state;
        adv        = 1'b0;
        req_ready  = '0;
        lut_rd     = 1'b0;
        lut_addr   = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    adv       = 1'b1;
                    req_ready = grant;
                    state_nxt = RD_BASE;
                end
            end
            RD_BASE: begin
                lut_rd    = 1'b1;
                lut_addr  = idx;
                state_nxt = RD_NEXT;
            end
            RD_NEXT: begin
                lut_rd    = 1'b1;
                lut_addr  = idx_nxt;
                state_nxt = CALC;
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = resp_oh;
                if (|(resp_ready & resp_oh)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            x_q    <= '0;
            base_q <= '0;
            y_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && adv) begin
                x_q <= x_sel;
            end
            if (state == RD_NEXT) begin
                base_q <= lut_data;
            end
            if (state == CALC) begin
                y_q <= y_calc;
            end
        end
    end

    assign resp_y = y_q;

endmodule

// File: tb/tb_act_interp_scheduler.sv
// Self-checking bench for act_interp_scheduler: directed cases plus random
// traffic against a job-level reference model.
module tb_act_interp_scheduler;

    localparam int N = 4;

`ifdef ACT_SAT_EN
    localparam logic [7:0] EXP_2F = 8'hA8;
`else
    localparam logic [7:0] EXP_2F = 8'h98;
`endif

    logic           clk        = 1'b0;
    logic           rst        = 1'b1;
    logic [N-1:0]   req_valid  = '0;
    logic [N*8-1:0] req_x      = '0;
    logic [N-1:0]   req_ready;
    logic           lut_rd;
    logic [3:0]     lut_addr;
    logic [7:0]     lut_data   = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [7:0]     resp_y;

    logic [7:0] lut [16];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    act_interp_scheduler #(.N_REQ(N), .DATA_W(8), .FRAC_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .lut_rd     (lut_rd),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y)
    );

    always #5 clk = ~clk;

    // Synchronous LUT memory and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lut_rd) lut_data <= lut[lut_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference result computed from x and the LUT with integer arithmetic.
    function automatic logic [7:0] ref_y(input int x);
        int idx, rem, b, n, d, s;
        idx = (x / 16) ^ 8;
        rem = x % 16;
        b   = int'($signed(lut[idx]));
        n   = int'($signed(lut[(idx == 15) ? 15 : idx + 1]));
`ifdef ACT_SAT_EN
        d = n - b;
        s = b + ((d * rem) >>> 4);
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`else
        d = (n - b) & 255;
        if (d > 127) d = d - 256;
        s = b + ((d * rem) >>> 4);
`endif
        return 8'(s);
    endfunction

    // Job-level model: one job at a time, round-robin pick, fixed timeline.
    int         m_busy = 0;
    int         m_age  = 0;
    int         m_lane = 0;
    int         m_idx  = 0;
    int         m_ptr  = 0;
    logic [7:0] m_y    = '0;

    always @(negedge clk) begin : mon
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        int pick, exp_addr, xi;
        if (!rst) begin
            m_busy = 0;
            m_ptr  = 0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_lut_rd", 32'(lut_rd), 32'd0);
            check("rst_lut_addr", 32'(lut_addr), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_y", 32'(resp_y), 32'd0);
        end else begin
            exp_rdy = '0;
            pick    = -1;
            if (m_busy == 0 && req_valid != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (pick < 0 && req_valid[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
                end
                exp_rdy[pick] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("lut_rd", 32'(lut_rd), 32'(m_busy != 0 && (m_age == 1 || m_age == 2)));
            exp_addr = 0;
            if (m_busy != 0 && m_age == 1) exp_addr = m_idx;
            if (m_busy != 0 && m_age == 2) exp_addr = (m_idx == 15) ? 15 : m_idx + 1;
            check("lut_addr", 32'(lut_addr), 32'(exp_addr));
            exp_rv = '0;
            if (m_busy != 0 && m_age >= 4) exp_rv[m_lane] = 1'b1;
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv != '0) check("resp_y", 32'(resp_y), 32'(m_y));
            if (m_busy != 0) begin
                if (m_age >= 4 && resp_ready[m_lane]) m_busy = 0;
                else m_age++;
            end
            if (pick >= 0) begin
                xi     = int'(req_x[pick*8 +: 8]);
                m_busy = 1;
                m_age  = 1;
                m_lane = pick;
                m_idx  = (xi / 16) ^ 8;
                m_y    = ref_y(xi);
                m_ptr  = (pick + 1) % N;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = '0;
        rst        = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = '1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run_single(input int lane, input logic [7:0] x, input logic [7:0] exp_y,
                              input string tag);
        int g_cyc;
        bit seen;
        @(posedge clk); #1;
        req_x               = '0;
        req_x[lane*8 +: 8]  = x;
        req_valid           = '0;
        req_valid[lane]     = 1'b1;
        resp_ready          = '1;
        seen  = 1'b0;
        g_cyc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[lane]) begin
                seen  = 1'b1;
                g_cyc = cyc;
            end
        end
        check({tag, "_grant"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid[lane]) seen = 1'b1;
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc - g_cyc), 32'd4);
        check({tag, "_y"}, 32'(resp_y), 32'(exp_y));
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int order [$];
        int hold;
        bit seen;

        for (int k = 0; k < 16; k++) lut[k] = 8'((k - 8) * 16);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Directed interpolation cases.
        run_single(0, 8'h25, 8'h25, "x25");
        run_single(0, 8'h7F, 8'h70, "x7f");
        run_single(0, 8'h80, 8'h80, "x80");
        lut[10] = 8'd100;
        lut[11] = 8'h9C;
        run_single(0, 8'h2F, EXP_2F, "x2f");
        for (int k = 0; k < 16; k++) lut[k] = 8'((k - 8) * 16);

        // All lanes requesting: strict rotation, each response held 3 cycles.
        do_reset();
        @(posedge clk); #1;
        req_x     = 32'h7F25_8043;
        req_valid = '1;
        hold      = 0;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
            @(posedge clk); #1;
            hold       = (resp_valid != '0) ? hold + 1 : 0;
            resp_ready = (hold > 3) ? resp_valid : '0;
        end
        check("order_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("order", 32'(order[i]), 32'(i % 4));

        // Reset while reading the second LUT entry.
        do_reset();
        @(posedge clk); #1;
        req_x     = $urandom;
        req_valid = 4'b0100;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[2]) seen = 1'b1;
        end
        check("abort_grant", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("abort_in_rd_next", 32'(lut_rd), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_lut_rd", 32'(lut_rd), 32'd0);
        check("abort_lut_addr", 32'(lut_addr), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_resp_y", 32'(resp_y), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        resp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        check("post_abort_grant", 32'(req_ready), 32'd1);
        drain();

        // Random traffic over random LUT contents.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) lut[k] = 8'($urandom);
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                req_valid  = 4'($urandom);
                req_x      = $urandom;
                resp_ready = 4'($urandom);
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
